// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM word, RAM handshake state and the memory arbiter FSM state.
// Latency: none (types only).
// Backpressure: none (types only).
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // RAM model handshake: FREE/BUSY mean "not done yet", ACCESS completes
   // the access this cycle, ERROR aborts it.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IACC  = 3'd1,
      DACC  = 3'd2,
      IDONE = 3'd3,
      DDONE = 3'd4
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access; data has
// priority, and a starvation counter forces a fetch grant after STARVE_MAX data grants.
// Latency: grant at the edge after the request, hit one edge after ACCESS.
// Backpressure: requesters hold their request until hit; FREE/BUSY extend the access.
//
// Ports:
//   CLK, nRST                   clock, synchronous active-low reset
//   iREN/iaddr -> iload/ihit    instruction fetch port
//   dREN/dWEN/daddr/dstore      data port request
//   dload/dhit                  data port response
//   ramREN/ramWEN/ramaddr/ramstore -> RAM,  ramload/ramstate <- RAM
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output word_t     iload,
   output logic      ihit,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output word_t     dload,
   output logic      dhit,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   localparam int            CW      = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   arb_state_t    state;
   arb_state_t    next_state;
   logic [CW-1:0] starve_cnt;
   logic          arb_ok;
   logic          data_req;
   logic          grant_d;
   logic          grant_i;

   // The DONE states arbitrate like IDLE so a pending request is granted two
   // cycles after the previous grant.
   always_comb begin
      arb_ok   = (state == IDLE) || (state == IDONE) || (state == DDONE);
      data_req = dREN | dWEN;
      grant_d  = arb_ok && data_req && ((starve_cnt != CNT_MAX) || !iREN);
      grant_i  = arb_ok && iREN && !grant_d;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, IDONE, DDONE: begin
            if (grant_d)      next_state = DACC;
            else if (grant_i) next_state = IACC;
            else              next_state = IDLE;
         end
         IACC: begin
            if (ramstate == ACCESS)     next_state = IDONE;
            else if (ramstate == ERROR) next_state = IDLE;
         end
         DACC: begin
            if (ramstate == ACCESS)     next_state = DDONE;
            else if (ramstate == ERROR) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state    <= IDLE;
         ramREN   <= 1'b0;
         ramWEN   <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         iload    <= '0;
         dload    <= '0;
         ihit     <= 1'b0;
         dhit     <= 1'b0;
      end else begin
         state <= next_state;
         ihit  <= 1'b0;
         dhit  <= 1'b0;
         case (state)
            IDLE, IDONE, DDONE: begin
               ramREN <= 1'b0;
               ramWEN <= 1'b0;
               if (grant_d) begin
                  // dREN together with dWEN is a write.
                  ramaddr  <= daddr;
                  ramstore <= dstore;
                  ramWEN   <= dWEN;
                  ramREN   <= !dWEN;
               end else if (grant_i) begin
                  ramaddr <= iaddr;
                  ramREN  <= 1'b1;
               end
            end
            IACC: begin
               if (ramstate == ACCESS) begin
                  iload  <= ramload;
                  ihit   <= 1'b1;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end else if (ramstate == ERROR) begin
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end
            end
            DACC: begin
               if (ramstate == ACCESS) begin
                  if (ramREN) dload <= ramload;
                  dhit   <= 1'b1;
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end else if (ramstate == ERROR) begin
                  ramREN <= 1'b0;
                  ramWEN <= 1'b0;
               end
            end
            default: begin
               ramREN <= 1'b0;
               ramWEN <= 1'b0;
            end
         endcase
      end
   end

   // Counts data grants taken while a fetch was waiting; saturates at STARVE_MAX.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         starve_cnt <= '0;
      end else if (grant_i) begin
         starve_cnt <= '0;
      end else if (grant_d) begin
         if (!iREN)                        starve_cnt <= '0;
         else if (starve_cnt != CNT_MAX)   starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, waited write, priority/starvation,
// ERROR retry and withdrawn request, with hand-computed expectations.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic      CLK;
   logic      nRST;
   logic      iREN;
   word_t     iaddr;
   word_t     iload;
   logic      ihit;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   word_t     dload;
   logic      dhit;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   int tests = 0;
   int fails = 0;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dhit(dhit),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
      tick; tick;
      tests++;
      if ({ramREN, ramWEN, ramaddr, ramstore, iload, dload, ihit, dhit} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: REN=%b WEN=%b addr=%h store=%h iload=%h dload=%h ihit=%b dhit=%b, want all 0",
                  ramREN, ramWEN, ramaddr, ramstore, iload, dload, ihit, dhit);
      end
      tests++;
      if (dut.state !== IDLE) begin
         fails++; $display("FAIL reset_state: got %0d want IDLE", dut.state);
      end
      nRST = 1'b1;
      tick;
   endtask

   task automatic test_single_fetch;
      iREN = 1; iaddr = 32'h40; ramstate = ACCESS; ramload = 32'h8C220004;
      tick;
      tests++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
         fails++; $display("FAIL fetch_grant: REN=%b WEN=%b addr=%h ihit=%b, want 1 0 00000040 0",
                           ramREN, ramWEN, ramaddr, ihit);
      end
      tick;
      tests++;
      if (ihit !== 1'b1 || iload !== 32'h8C220004 || ramREN !== 1'b0 || dhit !== 1'b0) begin
         fails++; $display("FAIL fetch_hit: ihit=%b iload=%h REN=%b dhit=%b, want 1 8c220004 0 0",
                           ihit, iload, ramREN, dhit);
      end
      iREN = 0;
      tick;
      tests++;
      if (ihit !== 1'b0 || dut.state !== IDLE || ramREN !== 1'b0) begin
         fails++; $display("FAIL fetch_end: ihit=%b state=%0d REN=%b, want 0 IDLE 0", ihit, dut.state, ramREN);
      end
   endtask

   task automatic test_reset_mid;
      dWEN = 1; daddr = 32'h200; dstore = 32'h55; ramstate = BUSY;
      tick;
      tests++;
      if (ramWEN !== 1'b1 || dut.state !== DACC) begin
         fails++; $display("FAIL midrst_grant: WEN=%b state=%0d, want 1 DACC", ramWEN, dut.state);
      end
      nRST = 0;
      tick;
      tests++;
      if ({ramREN, ramWEN, ramaddr, ramstore, iload, dload, ihit, dhit} !== '0 || dut.state !== IDLE) begin
         fails++;
         $display("FAIL midrst_clear: REN=%b WEN=%b addr=%h store=%h iload=%h dload=%h ihit=%b dhit=%b state=%0d, want all 0 IDLE",
                  ramREN, ramWEN, ramaddr, ramstore, iload, dload, ihit, dhit, dut.state);
      end
      dWEN = 0; nRST = 1; ramstate = ACCESS;
      for (int i = 0; i < 4; i++) begin
         tick;
         tests++;
         if (dhit !== 1'b0 || ramWEN !== 1'b0) begin
            fails++; $display("FAIL midrst_nohit: cycle %0d dhit=%b WEN=%b, want 0 0", i, dhit, ramWEN);
         end
      end
   endtask

   task automatic test_write_wait;
      dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY; ramload = 32'h11112222;
      tick;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 ||
             ramstore !== 32'hDEADBEEF || dhit !== 1'b0) begin
            fails++; $display("FAIL write_hold: cycle %0d WEN=%b REN=%b addr=%h store=%h dhit=%b, want 1 0 00000100 deadbeef 0",
                              i, ramWEN, ramREN, ramaddr, ramstore, dhit);
         end
         if (i == 3) ramstate = ACCESS;
         tick;
      end
      tests++;
      if (dhit !== 1'b1 || dload !== 32'h0 || ramWEN !== 1'b0) begin
         fails++; $display("FAIL write_hit: dhit=%b dload=%h WEN=%b, want 1 00000000 0", dhit, dload, ramWEN);
      end
      dWEN = 0;
      tick;
      tests++;
      if (dhit !== 1'b0 || dut.state !== IDLE) begin
         fails++; $display("FAIL write_end: dhit=%b state=%0d, want 0 IDLE", dhit, dut.state);
      end
   endtask

   task automatic test_priority;
      logic [9:0] exp_i;
      int n, cyc, last_hit;
      exp_i = 10'b1000010000;   // grant n is a fetch where bit n is 1
      iREN = 1; dREN = 1; iaddr = 32'h2000; daddr = 32'h1000;
      ramstate = ACCESS; ramload = 32'h12345678;
      n = 0; cyc = 0; last_hit = -1;
      while (n < 10 && cyc < 60) begin
         tick;
         cyc++;
         tests++;
         if (ihit && dhit) begin
            fails++; $display("FAIL prio_both_hits: cycle %0d ihit=%b dhit=%b", cyc, ihit, dhit);
         end
         if (ihit || dhit) begin
            tests++;
            if (ihit !== exp_i[n]) begin
               fails++; $display("FAIL prio_order: grant %0d got %s want %s", n,
                                 ihit ? "I" : "D", exp_i[n] ? "I" : "D");
            end
            if (dhit) begin
               tests++;
               if (dload !== 32'h12345678) begin
                  fails++; $display("FAIL prio_dload: got %h want 12345678", dload);
               end
            end
            if (last_hit >= 0) begin
               tests++;
               if (cyc - last_hit != 2) begin
                  fails++; $display("FAIL prio_interval: got %0d cycles want 2", cyc - last_hit);
               end
            end
            last_hit = cyc;
            if (dhit) daddr = daddr + 32'd4;
            else      iaddr = iaddr + 32'd4;
            n++;
            if (n == 10) begin iREN = 0; dREN = 0; end
         end
      end
      tests++;
      if (n < 10) begin
         fails++; $display("FAIL prio_timeout: got %0d hits want 10", n);
      end
      iREN = 0; dREN = 0;
      tick;
      tests++;
      if (dut.state !== IDLE) begin
         fails++; $display("FAIL prio_end: state=%0d want IDLE", dut.state);
      end
   endtask

   task automatic test_error_retry;
      dREN = 1; daddr = 32'h300; ramstate = ERROR;
      tick;
      tests++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
         fails++; $display("FAIL err_grant: REN=%b addr=%h, want 1 00000300", ramREN, ramaddr);
      end
      tick;
      tests++;
      if (ramREN !== 1'b0 || dhit !== 1'b0 || dut.state !== IDLE) begin
         fails++; $display("FAIL err_abort: REN=%b dhit=%b state=%0d, want 0 0 IDLE", ramREN, dhit, dut.state);
      end
      ramstate = ACCESS; ramload = 32'hCAFEF00D;
      tick;
      tests++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dhit !== 1'b0) begin
         fails++; $display("FAIL err_regrant: REN=%b addr=%h dhit=%b, want 1 00000300 0", ramREN, ramaddr, dhit);
      end
      tick;
      tests++;
      if (dhit !== 1'b1 || dload !== 32'hCAFEF00D) begin
         fails++; $display("FAIL err_hit: dhit=%b dload=%h, want 1 cafef00d", dhit, dload);
      end
      dREN = 0;
      tick;
      tests++;
      if (dhit !== 1'b0) begin
         fails++; $display("FAIL err_single: dhit=%b want 0", dhit);
      end
   endtask

   task automatic test_withdrawn;
      iREN = 1; iaddr = 32'h80; ramstate = BUSY;
      tick;
      tests++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h80 || dut.state !== IACC) begin
         fails++; $display("FAIL wd_grant: REN=%b addr=%h state=%0d, want 1 00000080 IACC", ramREN, ramaddr, dut.state);
      end
      iREN = 0; dREN = 1; daddr = 32'h400;
      tick;
      tests++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h80 || ihit !== 1'b0) begin
         fails++; $display("FAIL wd_hold: REN=%b addr=%h ihit=%b, want 1 00000080 0", ramREN, ramaddr, ihit);
      end
      ramstate = ACCESS; ramload = 32'h0000A5A5;
      tick;
      tests++;
      if (ihit !== 1'b1 || iload !== 32'h0000A5A5 || dhit !== 1'b0) begin
         fails++; $display("FAIL wd_ihit: ihit=%b iload=%h dhit=%b, want 1 0000a5a5 0", ihit, iload, dhit);
      end
      tick;
      tests++;
      if (ihit !== 1'b0 || ramREN !== 1'b1 || ramaddr !== 32'h400 || dut.state !== DACC) begin
         fails++; $display("FAIL wd_dgrant: ihit=%b REN=%b addr=%h state=%0d, want 0 1 00000400 DACC",
                           ihit, ramREN, ramaddr, dut.state);
      end
      tick;
      tests++;
      if (dhit !== 1'b1 || dload !== 32'h0000A5A5) begin
         fails++; $display("FAIL wd_dhit: dhit=%b dload=%h, want 1 0000a5a5", dhit, dload);
      end
      dREN = 0;
      tick;
      tests++;
      if (dhit !== 1'b0 || ihit !== 1'b0 || dut.state !== IDLE) begin
         fails++; $display("FAIL wd_end: dhit=%b ihit=%b state=%0d, want 0 0 IDLE", dhit, ihit, dut.state);
      end
   endtask

   initial begin
      test_reset;
      test_single_fetch;
      test_reset_mid;
      test_write_wait;
      test_priority;
      test_error_retry;
      test_withdrawn;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
